// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor, least-significant digit first, framed by vld/last.
// Optional signed-overflow port ovf enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_digit #(
   parameter int DIGIT_W = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vld,
   input  logic               last,
   input  logic               sub,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output logic [DIGIT_W-1:0] sum,
   output logic               sum_vld,
   output logic               sum_last,
   output logic               cout
`ifdef SERIAL_ADDSUB_OVF_EN
   ,
   output logic               ovf
`endif
);

   typedef enum logic {FIRST = 1'b0, MID = 1'b1} state_t;

   state_t             state_r, state_nxt_s;
   logic               carry_r, carry_nxt_s;
   logic               op_r, op_nxt_s;
   logic               op_s, cin_s;
   logic [DIGIT_W-1:0] b_adj_s;
   logic [DIGIT_W:0]   full_s;
   logic [DIGIT_W-1:0] s_s;
   logic               c_s;

   // Per-digit arithmetic: the first digit of a word takes op and carry-in from sub.
   always_comb begin
      op_s  = sub;
      cin_s = sub;
      case (state_r)
         FIRST: begin
            op_s  = sub;
            cin_s = sub;
         end
         MID: begin
            op_s  = op_r;
            cin_s = carry_r;
         end
         default: begin
            op_s  = sub;
            cin_s = sub;
         end
      endcase
      b_adj_s = op_s ? ~b : b;
      full_s  = {1'b0, a} + {1'b0, b_adj_s} + {{DIGIT_W{1'b0}}, cin_s};
      s_s     = full_s[DIGIT_W-1:0];
      c_s     = full_s[DIGIT_W];
   end

   // Next-state: a last digit closes the word and clears the carry so nothing leaks.
   always_comb begin
      state_nxt_s = state_r;
      carry_nxt_s = carry_r;
      op_nxt_s    = op_r;
      if (vld) begin
         op_nxt_s = op_s;
         if (last) begin
            state_nxt_s = FIRST;
            carry_nxt_s = 1'b0;
         end else begin
            state_nxt_s = MID;
            carry_nxt_s = c_s;
         end
      end else begin
         state_nxt_s = state_r;
         carry_nxt_s = carry_r;
         op_nxt_s    = op_r;
      end
   end

   // Word-framing state, carry and latched operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FIRST;
         carry_r <= 1'b0;
         op_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         carry_r <= carry_nxt_s;
         op_r    <= op_nxt_s;
      end
   end

   // Registered result digit and framing; sum holds across idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum      <= {DIGIT_W{1'b0}};
         sum_vld  <= 1'b0;
         sum_last <= 1'b0;
         cout     <= 1'b0;
      end else if (vld) begin
         sum      <= s_s;
         sum_vld  <= 1'b1;
         sum_last <= last;
         cout     <= last ? c_s : 1'b0;
      end else begin
         sum_vld  <= 1'b0;
         sum_last <= 1'b0;
         cout     <= 1'b0;
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_s;

   // Signed overflow: carry into the MSB differs from carry out of the MSB.
   always_comb begin
      ovf_s = a[DIGIT_W-1] ^ b_adj_s[DIGIT_W-1] ^ s_s[DIGIT_W-1] ^ c_s;
   end

   // Overflow flag is reported only alongside the last digit of a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (vld && last) begin
         ovf <= ovf_s;
      end else begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Scoreboard bench for serial_addsub_digit: one instance with DIGIT_W=1 and one with DIGIT_W=4.
module tb_serial_addsub_digit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v1, l1, s1;
   logic [0:0] a1, b1, sum1;
   logic       sv1, sl1, co1, ovf1;
   logic       v4, l4, s4;
   logic [3:0] a4, b4, sum4;
   logic       sv4, sl4, co4, ovf4;

   serial_addsub_digit #(.DIGIT_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .vld(v1), .last(l1), .sub(s1), .a(a1), .b(b1),
      .sum(sum1), .sum_vld(sv1), .sum_last(sl1), .cout(co1)
`ifdef SERIAL_ADDSUB_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_addsub_digit #(.DIGIT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .vld(v4), .last(l4), .sub(s4), .a(a4), .b(b4),
      .sum(sum4), .sum_vld(sv4), .sum_last(sl4), .cout(co4)
`ifdef SERIAL_ADDSUB_OVF_EN
      , .ovf(ovf4)
`endif
   );

`ifndef SERIAL_ADDSUB_OVF_EN
   assign ovf1 = 1'b0;
   assign ovf4 = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] sum;
      logic       last;
      logic       cout;
      logic       ovf;
   } exp_t;

   exp_t       q1[$];
   exp_t       q4[$];
   exp_t       e1, e4;
   logic [3:0] prev1, prev4;
   int         checks   = 0;
   int         failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever an output digit is presented.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev1 = 4'h0;
         prev4 = 4'h0;
      end else begin
         if (sv1) begin
            if (q1.size() == 0) begin
               chk("w1_unexpected_digit", 32'd1, 32'd0);
            end else begin
               e1 = q1.pop_front();
               chk("w1_sum", {31'd0, sum1}, {28'd0, e1.sum});
               chk("w1_last", {31'd0, sl1}, {31'd0, e1.last});
               chk("w1_cout", {31'd0, co1}, {31'd0, e1.cout});
`ifdef SERIAL_ADDSUB_OVF_EN
               chk("w1_ovf", {31'd0, ovf1}, {31'd0, e1.ovf});
`endif
               prev1 = e1.sum;
            end
         end else begin
            chk("w1_idle_sum_held", {31'd0, sum1}, {28'd0, prev1});
            chk("w1_idle_flags", {30'd0, sl1, co1}, 32'd0);
         end
         if (sv4) begin
            if (q4.size() == 0) begin
               chk("w4_unexpected_digit", 32'd1, 32'd0);
            end else begin
               e4 = q4.pop_front();
               chk("w4_sum", {28'd0, sum4}, {28'd0, e4.sum});
               chk("w4_last", {31'd0, sl4}, {31'd0, e4.last});
               chk("w4_cout", {31'd0, co4}, {31'd0, e4.cout});
`ifdef SERIAL_ADDSUB_OVF_EN
               chk("w4_ovf", {31'd0, ovf4}, {31'd0, e4.ovf});
`endif
               prev4 = e4.sum;
            end
         end else begin
            chk("w4_idle_sum_held", {28'd0, sum4}, {28'd0, prev4});
            chk("w4_idle_flags", {29'd0, sl4, co4, ovf4}, 32'd0);
         end
      end
   end

   task automatic step1(input logic v, input logic l, input logic s, input logic a, input logic b);
      v1 = v; l1 = l; s1 = s; a1 = a; b1 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic step4(input logic v, input logic l, input logic s, input logic [3:0] a,
                        input logic [3:0] b);
      v4 = v; l4 = l; s4 = s; a4 = a; b4 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input logic sm, input logic l, input logic c, input logic o);
      q1.push_back('{sum: {3'b000, sm}, last: l, cout: c, ovf: o});
   endtask

   task automatic push4(input logic [3:0] sm, input logic l, input logic c, input logic o);
      q4.push_back('{sum: sm, last: l, cout: c, ovf: o});
   endtask

   initial begin
      rst_n = 1'b0;
      v1 = 1'b0; l1 = 1'b0; s1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      v4 = 1'b0; l4 = 1'b0; s4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {22'd0, sum4, sv4, sl4, co4, ovf4, sum1, sv1, sl1, co1}, 32'd0);
      rst_n = 1'b1;
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      // 5+3 bit-serial: 0,0,0,1 with cout=0; signed 4-bit overflow
      push1(1'b0, 1'b0, 1'b0, 1'b0); step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      push1(1'b0, 1'b0, 1'b0, 1'b0); step1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      push1(1'b0, 1'b0, 1'b0, 1'b0); step1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      push1(1'b1, 1'b1, 1'b0, 1'b1); step1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 0x12-0x34 = 0xDE, borrow
      push4(4'hE, 1'b0, 1'b0, 1'b0); step4(1'b1, 1'b0, 1'b1, 4'h2, 4'h4);
      push4(4'hD, 1'b1, 1'b0, 1'b0); step4(1'b1, 1'b1, 1'b1, 4'h1, 4'h3);
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      // Same with a 3-cycle gap and sub flipped after the first digit
      push4(4'hE, 1'b0, 1'b0, 1'b0); step4(1'b1, 1'b0, 1'b1, 4'h2, 4'h4);
      repeat (3) step4(1'b0, 1'b0, 1'b0, 4'h9, 4'h9);
      push4(4'hD, 1'b1, 1'b0, 1'b0); step4(1'b1, 1'b1, 1'b0, 4'h1, 4'h3);
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      // Back-to-back single-digit words
      push4(4'h0, 1'b1, 1'b1, 1'b0); step4(1'b1, 1'b1, 1'b0, 4'hF, 4'h1);
      push4(4'h2, 1'b1, 1'b1, 1'b0); step4(1'b1, 1'b1, 1'b1, 4'h3, 4'h1);
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      // Abandon a word with carry pending via asynchronous reset
      push4(4'h1, 1'b0, 1'b0, 1'b0); step4(1'b1, 1'b0, 1'b0, 4'hF, 4'h2);
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {22'd0, sum4, sv4, sl4, co4, ovf4, sum1, sv1, sl1, co1}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push4(4'h5, 1'b1, 1'b0, 1'b0); step4(1'b1, 1'b1, 1'b0, 4'h2, 4'h3);
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      // Signed overflow cases
      push4(4'h8, 1'b1, 1'b0, 1'b1); step4(1'b1, 1'b1, 1'b0, 4'h7, 4'h1);
      push4(4'h7, 1'b1, 1'b1, 1'b1); step4(1'b1, 1'b1, 1'b1, 4'h8, 4'h1);
      step4(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

      for (int i = 0; i < 20; i++) begin
         if (q1.size() != 0 || q4.size() != 0) begin
            @(posedge clk);
            #1;
         end
      end
      chk("scoreboard_drained", q1.size() + q4.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_addsub_digit.md
# serial_addsub_digit

Serial adder/subtractor that processes one DIGIT_W-bit digit of two operands per valid cycle, least-significant digit first, framed by vld/last. It generalises the single-bit serial adder to configurable digit width and adds a per-word add/subtract mode, a registered output handshake, and a final carry/borrow flag. It sits in the sequential-basics datapath wherever multi-cycle operands arrive as a digit stream.

## Interface
- DIGIT_W, default 1: bits per digit processed per cycle; legal range ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vld  input  1  input digit valid.
- last  input  1  current digit is the most-significant digit of the word; ignored unless vld=1.
- sub  input  1  0 = a+b, 1 = a−b; sampled only on the first digit of a word.
- a  input  DIGIT_W  operand A digit.
- b  input  DIGIT_W  operand B digit.
- sum  output  DIGIT_W  result digit, registered.
- sum_vld  output  1  sum holds a new result digit this cycle.
- sum_last  output  1  sum is the final digit of the word.
- cout  output  1  final carry out (add) or no-borrow flag (sub); meaningful only when sum_vld=1 and sum_last=1, otherwise 0.
- ovf  output  1  signed overflow of the word; only present with SERIAL_ADDSUB_OVF_EN.

## Operation
- State: FIRST (next valid digit starts a word) and MID (word in progress); plus a carry register and a latched op bit.
- On vld in FIRST: op ← sub, carry-in = sub. On vld in MID: use the latched op, carry-in = carry register.
- Digit arithmetic: {c, s} = a + (op ? ~b : b) + cin, computed at DIGIT_W+1 bits; s is the DIGIT_W-bit result, c the carry out.
- On vld: sum ← s, sum_vld ← 1, sum_last ← last, carry ← c.
- If vld and last: cout ← c, state → FIRST, carry ← 0. Otherwise, if vld: cout ← 0, state → MID.
- On vld=0: sum_vld, sum_last and cout ← 0; sum holds its previous value; state, carry and op hold. Gaps of any length mid-word are legal.
- A change of sub mid-word is ignored.
- Single-digit words (vld & last in FIRST) are legal.
- Back-to-back words: the digit after a last starts a fresh word with no carry leakage.
- There is no backpressure; every valid input digit produces exactly one output digit.

## Timing
- Latency: 1 cycle from an input digit to its output digit; throughput is one digit per cycle.
- Reset (rst_n=0, asynchronous, effective immediately): sum=0, sum_vld=0, sum_last=0, cout=0, ovf=0, state=FIRST, carry=0, op=0.
- Reset mid-word abandons the word; the first vld after release starts a new word.
- Deassertion of rst_n must meet recovery/removal timing relative to clk; inputs in the release cycle are honoured.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: the ovf port exists.
  - On a vld & last digit: ovf ← (carry into the MSB of the digit) XOR (carry out of the digit).
  - Carry into the MSB = a[MSB] ^ b'[MSB] ^ s[MSB], where b' is the op-adjusted b.
  - ovf is 0 on every other cycle.
- SERIAL_ADDSUB_OVF_EN undefined: there is no ovf port and no overflow logic; all other behaviour is identical.

## Test plan
- DIGIT_W=1, sub=0, 5+3 as 4 digits (a=1,0,1,0; b=1,1,0,0; last on the 4th) -> sum digits 0,0,0,1 (=8), sum_last on the 4th output, cout=0.
- DIGIT_W=4, sub=1, 0x12−0x34 as 2 digits -> sum 0xE then 0xD (=0xDE), cout=0 (borrow), ovf=0.
- Repeat the previous case with 3 idle cycles between the digits and sub toggled during the gap -> identical result; sum_vld low during the gap and sum held.
- DIGIT_W=4, single-digit word 0xF+0x1 followed next cycle by single-digit word 0x3−0x1 -> sum 0x0 with cout=1, then sum 0x2 with cout=1; no carry leakage.
- Assert rst_n=0 asynchronously mid-word -> all outputs 0 before the next edge; after release, 0x2+0x3 (DIGIT_W=4) -> sum 0x5, cout=0.
- With SERIAL_ADDSUB_OVF_EN, DIGIT_W=4: 0x7+0x1 -> sum 0x8, ovf=1, cout=0; 0x8−0x1 -> sum 0x7, ovf=1, cout=1.
